// File: rtl/inst_fetch_stage.sv
// Instruction fetch stage: walks the PC, drives BRAM port A as a read-only
// master and hands {inst, pc} to the decoder through a small skid buffer.
module inst_fetch_stage #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 36,
    parameter int DEPTH  = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_en,
    input  logic              io_flush,
    input  logic [ADDR_W-1:0] io_flushPC,
    output logic              io_bram_en,
    output logic              io_bram_writeEn,
    output logic [ADDR_W-1:0] io_bram_addr,
    output logic [DATA_W-1:0] io_bram_dataIn,
    input  logic [DATA_W-1:0] io_bram_dataOut,
    output logic              io_deq_valid,
    input  logic              io_deq_ready,
    output logic [DATA_W-1:0] io_deq_bits_inst,
    output logic [ADDR_W-1:0] io_deq_bits_pc
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W:0] OCC_MAX = (CNT_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    generate
        if (DEPTH < 2) begin : g_depth_check
            $error("inst_fetch_stage: DEPTH must be at least 2");
        end
    endgenerate

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] issued_pc_q, issued_pc_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;

    logic [DATA_W-1:0] inst_q [DEPTH];
    logic [ADDR_W-1:0] pcbuf_q [DEPTH];

    logic              deq_fire;
    logic              capture;
    logic              issue;
    logic [CNT_W:0]    occ;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // Handshake, issue and capture decisions for this cycle.
    always_comb begin
        io_deq_valid = (count_q != '0);
        deq_fire     = io_deq_valid & io_deq_ready;
        occ          = {1'b0, count_q} + (CNT_W + 1)'(inflight_q);
        // Reset gating keeps the port quiet while reset is held.
        issue        = io_en & ~io_flush & ~reset
                     & ((occ < OCC_MAX) | deq_fire);
        capture      = inflight_q & ~io_flush;
    end

    // BRAM port A and decoder-side outputs.
    always_comb begin
        io_bram_en       = issue;
        io_bram_writeEn  = 1'b0;
        io_bram_addr     = pc_q;
        io_bram_dataIn   = '0;
        io_deq_bits_inst = inst_q[head_q];
        io_deq_bits_pc   = pcbuf_q[head_q];
    end

    // Next-state for PC, in-flight tracking and buffer bookkeeping.
    always_comb begin
        pc_d        = pc_q;
        inflight_d  = issue;
        issued_pc_d = issue ? pc_q : issued_pc_q;
        count_d     = count_q + CNT_W'(capture) - CNT_W'(deq_fire);
        head_d      = deq_fire ? ptr_next(head_q) : head_q;
        tail_d      = capture ? ptr_next(tail_q) : tail_q;
        if (io_flush) begin
            // Redirect drops everything buffered or still in flight.
            pc_d       = io_flushPC;
            inflight_d = 1'b0;
            count_d    = '0;
            head_d     = '0;
            tail_d     = '0;
        end else if (issue) begin
            pc_d = pc_q + ADDR_W'(1);
        end
    end

    // Control state registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q        <= '0;
            inflight_q  <= 1'b0;
            issued_pc_q <= '0;
            count_q     <= '0;
            head_q      <= '0;
            tail_q      <= '0;
        end else begin
            pc_q        <= pc_d;
            inflight_q  <= inflight_d;
            issued_pc_q <= issued_pc_d;
            count_q     <= count_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
        end
    end

    // Buffer payload; validity lives entirely in count/pointers.
    always_ff @(posedge clock) begin
        if (capture) begin
            inst_q[tail_q]  <= io_bram_dataOut;
            pcbuf_q[tail_q] <= issued_pc_q;
        end
    end

endmodule
